// File: rtl/uart_rx_if.sv
// Serial-receive bundle between the line/tick source and the uart_rx core.
// The master side owns the serial line and the oversampling tick; the slave
// side (the receiver) returns the received byte and its status strobes.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 os_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output os_tick,
    output rx,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  os_tick,
    input  rx,
    output data,
    output valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by an oversampling tick from the shared baud
// generator. Delivers each good byte with a one-cycle valid strobe and a bad
// stop bit with a one-cycle frame_err strobe.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | line idle; waiting for a falling edge while armed
// S_START | counting to the middle of the start bit to reject glitches
// S_DATA  | sampling DATA_BITS data bits, LSB first, one per bit period
// S_STOP  | sampling the stop bit; strobes valid or frame_err, then idles
//
// OVERSAMPLE must be even and >= 4 so the mid-start-bit count is meaningful.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave rx_bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID_START = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST      = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST       = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]           r_sync;
  logic                 w_rx_s;
  logic                 r_armed;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;

  logic                 w_busy;
  logic                 w_start_det;
  logic                 w_start_mid;
  logic                 w_bit_mid;
  logic                 w_stop_mid;

  // Two-flop synchroniser for the asynchronous serial line; resets to idle-high
  // so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx_bus.rx};
    end
  end

  assign w_rx_s = r_sync[1];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a start bit that is high again at its midpoint is a glitch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_det) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_start_mid) begin
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_mid && (r_bit_cnt == BIT_LAST)) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_stop_mid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/decode logic: busy plus the per-state sample points. Ticks are only
  // qualified outside IDLE, so a tick coinciding with start detection is dropped.
  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_start_det = 1'b0;
    w_start_mid = 1'b0;
    w_bit_mid   = 1'b0;
    w_stop_mid  = 1'b0;
    case (r_state)
      S_IDLE:  w_start_det = r_armed && !w_rx_s;
      S_START: w_start_mid = rx_bus.os_tick && (r_tick_cnt == TICK_MID_START);
      S_DATA:  w_bit_mid   = rx_bus.os_tick && (r_tick_cnt == TICK_LAST);
      S_STOP:  w_stop_mid  = rx_bus.os_tick && (r_tick_cnt == TICK_LAST);
      default: ;
    endcase
  end

  // Datapath: tick/bit counters, shift register, armed flag, output byte and
  // the one-cycle strobes (valid and frame_err are mutually exclusive by
  // construction since both depend on the same stop sample).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_armed     <= 1'b1;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tick_cnt <= '0;
          if (w_rx_s) begin
            r_armed <= 1'b1;
          end
        end
        S_START: begin
          if (rx_bus.os_tick) begin
            if (w_start_mid) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        S_DATA: begin
          if (rx_bus.os_tick) begin
            if (w_bit_mid) begin
              r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
              r_tick_cnt <= '0;
              r_bit_cnt  <= r_bit_cnt + BW'(1);
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        S_STOP: begin
          if (rx_bus.os_tick) begin
            if (w_stop_mid) begin
              r_tick_cnt <= '0;
              if (w_rx_s) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                // Low stop bit may be a break: disarm until the line goes high.
                r_frame_err <= 1'b1;
                r_armed     <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_bus.data      = r_data;
  assign rx_bus.valid     = r_valid;
  assign rx_bus.frame_err = r_frame_err;
  assign rx_bus.busy      = w_busy;

endmodule
